// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded 4-bit counter family (up and down).
package counter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BIN_MAX = 4'd15;

  // Largest value a digit holds before wrapping: 9 for decimal, 15 for binary.
  function automatic logic [DIGIT_W-1:0] digit_max(input logic bcd);
    return bcd ? BCD_MAX : BIN_MAX;
  endfunction

endpackage

// File: rtl/down_digit.sv
// One 4-bit down-counting digit. The parent decides when the digit steps,
// reloads or loads. The digit only applies the highest-priority request.
module down_digit
  import counter_pkg::*;
(
  input  logic               CLK,
  input  logic               MR,       // synchronous, active-low
  input  logic               load,     // active-high strobe: take d
  input  logic               reload,   // active-high strobe: take rld_val
  input  logic               step,     // active-high strobe: count down by one
  input  logic [DIGIT_W-1:0] wrap,     // value taken when stepping from zero
  input  logic [DIGIT_W-1:0] rld_val,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               zero
);

  // Digit register: reset > load > reload > step > hold.
  // A loaded value above the wrap value simply counts down with no correction.
  always_ff @(posedge CLK) begin
    if (!MR) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (reload) begin
      q <= rld_val;
    end else if (step) begin
      q <= (q == '0) ? wrap : q - DIGIT_W'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/down_counter_cascade.sv
// Presettable down counter built from cascaded 4-bit digits. It produces a
// combinational borrow (BO) for chaining stages and a registered one-cycle
// terminal-count pulse (TC). With RLD high it reloads the last preset on
// underflow, so it also works as a divide-by-(N+1) interval timer.
module down_counter_cascade
  import counter_pkg::*;
#(
  parameter int DIGITS = 2,   // 1..4
  parameter bit BCD    = 1'b1
) (
  input  logic                      CLK,
  input  logic                      MR,    // synchronous, active-low
  input  logic                      Load,  // synchronous, active-low
  input  logic                      EN,
  input  logic                      RLD,
  input  logic [DIGIT_W*DIGITS-1:0] D,
  output logic [DIGIT_W*DIGITS-1:0] Q,
  output logic                      BO,
  output logic                      TC
);

  localparam int W = DIGIT_W * DIGITS;

  // borrow[k] is EN qualified by "all digits below k are zero".
  // borrow[DIGITS] is therefore EN && (Q == 0), which is the underflow
  // condition and the external borrow.
  logic [DIGITS:0]   borrow;
  logic [DIGITS-1:0] zero;
  logic [W-1:0]      reload_q;
  logic              underflow;
  logic              do_load;
  logic              do_reload;

  assign borrow[0] = EN;
  assign underflow = borrow[DIGITS];
  assign BO        = underflow;
  assign do_load   = ~Load;
  // During underflow every digit also sees step. Reload takes priority in
  // the digit, and with RLD low the wrap of all digits gives all-max.
  assign do_reload = underflow & RLD;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign borrow[k+1] = borrow[k] & zero[k];

    down_digit u_digit (
      .CLK     (CLK),
      .MR      (MR),
      .load    (do_load),
      .reload  (do_reload),
      .step    (borrow[k]),
      .wrap    (digit_max(BCD)),
      .rld_val (reload_q[k*DIGIT_W +: DIGIT_W]),
      .d       (D[k*DIGIT_W +: DIGIT_W]),
      .q       (Q[k*DIGIT_W +: DIGIT_W]),
      .zero    (zero[k])
    );
  end

  // Reload register captures the preset on every parallel load.
  always_ff @(posedge CLK) begin
    if (!MR) begin
      reload_q <= '0;
    end else if (!Load) begin
      reload_q <= D;
    end
  end

  // Terminal count: high for the single cycle after an enabled underflow.
  // A load or reset on the underflow edge suppresses it.
  always_ff @(posedge CLK) begin
    if (!MR || !Load) begin
      TC <= 1'b0;
    end else begin
      TC <= underflow;
    end
  end

endmodule

// File: doc/down_counter_cascade.md
# down_counter_cascade

Synchronous presettable down counter, the count-down counterpart of the team's 4-bit up counter (MR/Load/EN/D/Q/CO). It is built from cascaded 4-bit digits, each binary or BCD. It emits a combinational borrow for cascading and a registered terminal-count pulse. It can auto-reload a preset value on underflow, so it also serves as a programmable divider or interval timer.

## Interface
- DIGITS, 2, number of cascaded 4-bit digits (1..4)
- BCD, 1, 1 = each digit counts 9..0; 0 = each digit counts 15..0
- CLK  in  1  rising-edge clock
- MR  in  1  master reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- Load  in  1  parallel load, synchronous, active-low
- EN  in  1  count enable, active-high
- RLD  in  1  auto-reload enable, active-high
- D  in  4*DIGITS  preset value, digit 0 in D[3:0]
- Q  out  4*DIGITS  current count
- BO  out  1  borrow out, combinational: EN && (Q == 0)
- TC  out  1  registered terminal-count pulse, one cycle wide

## Operation
- Priority at each rising CLK: MR low > Load low > EN high > hold.
- MR low: Q = 0, reload register = 0, TC = 0.
- Load low: Q = D and reload register = D. TC = 0. EN is ignored that cycle.
- EN high, Q != 0: Q decrements by 1.
  - Digit 0 always steps.
  - Digit k steps only when digits 0..k-1 are all zero (internal borrow chain).
  - A stepping digit at 0 wraps to 9 (BCD=1) or 15 (BCD=0).
- EN high, Q == 0 (underflow):
  - RLD high: Q = reload register.
  - RLD low: every digit wraps (all-9 for BCD, all-F for binary).
  - TC = 1 on the following cycle in both cases.
- EN low: Q holds, TC = 0.
- BCD=1 and a loaded digit is >9: the value is held as is and decrements normally (12 -> 11 -> ... -> 0 -> 9). There is no correction.
- Reload register = 0 with RLD high: Q stays 0. BO stays high and TC pulses on every enabled cycle (divide-by-1).
- RLD is sampled only in the underflow cycle. Changing it mid-count has no other effect.

## Timing
- Reset values: Q = 0, TC = 0, reload register = 0. BO = EN immediately after reset.
- Q: 1-cycle latency from a Load or EN sample to the updated value.
- TC: high for exactly the one cycle after the underflow edge. With RLD high and reload register = N > 0, the period is N+1 enabled cycles.
- BO: combinational, no register. It follows EN within the same cycle and feeds the next stage's EN for cascading.
- Load low together with underflow: the load wins and TC = 0.
- MR low mid-count: everything clears on that edge. A pending TC is suppressed.
- MR or Load asserted for several cycles: the state is held at the reset or loaded value.

## Structure
- Sub-module `down_digit`: one 4-bit digit.
  - Ports: CLK, MR, load, step, wrap value, reload nibble, D nibble.
  - Outputs: Q nibble and zero flag.
- Top level holds:
  - the generate loop over DIGITS;
  - the borrow chain (AND of lower-digit zero flags with EN);
  - the reload register;
  - the TC flop.
- Shared package `counter_pkg`:
  - DIGIT_W = 4;
  - BCD_MAX = 4'd9;
  - BIN_MAX = 4'd15;
  - function `digit_max(bcd)`.
  - The up-counter also reuses this package.

## Test plan
Clock period 100 ns; DIGITS=2 unless stated.
- Reset: MR=0 for 2 cycles, EN=1 -> Q=8'h00, TC=0, BO=1. Release MR with EN=0 -> Q holds 00, BO=0.
- BCD load/count, BCD=1: Load=0 with D=8'h12, then EN=1 for 13 cycles, RLD=0 -> Q = 12, 11, 10, 09 … 00, then 99. TC is high only in the cycle after 00->99. BO is high only while Q=00.
- Auto-reload divider: BCD=0, D=8'h03, RLD=1, EN=1 continuous -> Q cycles 03, 02, 01, 00, 03 … TC pulses every 4 cycles and is one cycle wide.
- Priority: Load=0 in the same cycle Q=00 with EN=1 and D=8'h05 -> Q=05 and TC=0. Then EN=0 for 3 cycles -> Q holds 05.
- Cascade: BO of instance A drives EN of instance B (DIGITS=1, BCD=1 each). A loaded with 2, B with 1, A's RLD=0 -> B decrements exactly once per A underflow.
- Mid-operation reset and edge values:
  - MR=0 asserted while Q=07 counting -> Q=00 next edge and TC=0. The reload register clears, so an immediate underflow with RLD=1 gives Q=00.
  - BCD=1 with D=8'h0F -> 0F, 0E … 00, 99.
